// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - decode stage: splits fields, assembles two-word LDI, drives do_swap (optional DECODE_STATS_EN counters)
module instr_decode_stage #(
    parameter int IW   = 9,
    parameter int RW   = 2,
    parameter int IMMW = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IW-1:0]   in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_op,
    output logic [RW-1:0]   out_reg1,
    output logic [RW-1:0]   out_reg2,
    output logic [1:0]      out_func,
    output logic [IMMW-1:0] out_imm,
    output logic            out_is_ldi,
    output logic            do_swap
`ifdef DECODE_STATS_EN
    ,
    output logic [15:0]     stat_ops,
    output logic [15:0]     stat_swaps
`endif
);

    localparam logic [2:0] OP_LDI  = 3'b110;
    localparam logic [2:0] OP_SWAP = 3'b111;

    typedef enum logic {S_OP, S_IMM} state_t;

    state_t          state, state_next;
    logic [RW-1:0]   hdr_reg1, hdr_reg2;
    logic [1:0]      hdr_func;

    logic [2:0]      in_op;
    logic            accept, fire, fire_q, load, hdr_capture;

    assign in_op    = in_instr[IW-1:IW-3];
    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid && out_ready;
    // a flushed cycle retires nothing, so neither the strobe nor the counters see it
    assign fire_q   = fire && !flush;
    assign do_swap  = fire_q && (out_op == OP_SWAP);

    assign load        = accept && ((state == S_IMM) || (in_op != OP_LDI));
    assign hdr_capture = accept && (state == S_OP) && (in_op == OP_LDI);

    always_comb begin
        state_next = state;
        case (state)
            S_OP:    if (hdr_capture) state_next = S_IMM;
            S_IMM:   if (accept)      state_next = S_OP;
            default:                  state_next = S_OP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            state <= S_OP;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            hdr_reg1 <= '0;
            hdr_reg2 <= '0;
            hdr_func <= '0;
        end else if (hdr_capture) begin
            hdr_reg1 <= in_instr[5:4];
            hdr_reg2 <= in_instr[3:2];
            hdr_func <= in_instr[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_op     <= '0;
            out_reg1   <= '0;
            out_reg2   <= '0;
            out_func   <= '0;
            out_imm    <= '0;
            out_is_ldi <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            if (state == S_IMM) begin
                out_op     <= OP_LDI;
                out_reg1   <= hdr_reg1;
                out_reg2   <= hdr_reg2;
                out_func   <= hdr_func;
                out_imm    <= in_instr;
                out_is_ldi <= 1'b1;
            end else begin
                out_op     <= in_op;
                out_reg1   <= in_instr[5:4];
                out_reg2   <= in_instr[3:2];
                out_func   <= in_instr[1:0];
                out_imm    <= '0;
                out_is_ldi <= 1'b0;
            end
        end else if (fire) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DECODE_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_ops   <= '0;
            stat_swaps <= '0;
        end else begin
            if (fire_q && stat_ops != 16'hFFFF)
                stat_ops <= stat_ops + 16'd1;
            if (do_swap && stat_swaps != 16'hFFFF)
                stat_swaps <= stat_swaps + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - randomized self-checking bench for instr_decode_stage
module tb_instr_decode_stage;

    logic       clk = 1'b0;
    logic       reset, flush, in_valid, out_ready;
    logic [8:0] in_instr;
    logic       in_ready, out_valid, out_is_ldi, do_swap;
    logic [2:0] out_op;
    logic [1:0] out_reg1, out_reg2, out_func;
    logic [8:0] out_imm;
`ifdef DECODE_STATS_EN
    logic [15:0] stat_ops, stat_swaps;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] r1;
        logic [1:0] r2;
        logic [1:0] func;
        logic [8:0] imm;
        logic       ldi;
    } op_t;

    op_t        exp_q[$];
    logic       pend;
    logic [8:0] pend_word;

    instr_decode_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_reg1(out_reg1), .out_reg2(out_reg2),
        .out_func(out_func), .out_imm(out_imm), .out_is_ldi(out_is_ldi),
        .do_swap(do_swap)
`ifdef DECODE_STATS_EN
        , .stat_ops(stat_ops), .stat_swaps(stat_swaps)
`endif
    );

    always #5 clk = ~clk;

    // Word-stream model: an LDI header waits for its immediate, everything else is one op.
    function automatic void model_word(input logic [8:0] w);
        op_t e;
        if (pend) begin
            e = '{op: 3'b110, r1: pend_word[5:4], r2: pend_word[3:2], func: pend_word[1:0], imm: w, ldi: 1'b1};
            pend = 1'b0;
            exp_q.push_back(e);
        end else if (w[8:6] == 3'b110) begin
            pend      = 1'b1;
            pend_word = w;
        end else begin
            e = '{op: w[8:6], r1: w[5:4], r2: w[3:2], func: w[1:0], imm: 9'd0, ldi: 1'b0};
            exp_q.push_back(e);
        end
    endfunction

    task automatic cycle();
        op_t  e;
        logic exp_rdy;
        @(negedge clk);
        exp_rdy = !flush && (!out_valid || out_ready);
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready act=%b exp=%b", in_ready, exp_rdy);
        end
        if (!reset) begin
            exp_q.delete();
            pend = 1'b0;
        end else if (flush) begin
            checks++;
            if (do_swap !== 1'b0) begin
                errors++;
                $display("FAIL do_swap_flush act=%b exp=0", do_swap);
            end
            if (out_valid && exp_q.size() > 0) void'(exp_q.pop_front());
            pend = 1'b0;
        end else begin
            checks++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_op act=op%0d exp=none", out_op);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_op, out_reg1, out_reg2, out_func, out_imm, out_is_ldi, do_swap}
                        !== {e, (e.op == 3'b111)}) begin
                        errors++;
                        $display("FAIL op_payload act=%h exp=%h",
                                 {out_op, out_reg1, out_reg2, out_func, out_imm, out_is_ldi, do_swap},
                                 {e, (e.op == 3'b111)});
                    end
                end
            end else if (do_swap !== 1'b0) begin
                errors++;
                $display("FAIL do_swap_idle act=%b exp=0", do_swap);
            end
            if (in_valid && in_ready) model_word(in_instr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_instr = 9'h1A5;
        repeat (2) cycle();
        checks++;
        if ({out_valid, do_swap, out_imm, out_is_ldi, out_op} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state act=%h exp=0", {out_valid, do_swap, out_imm, out_is_ldi, out_op});
        end
        reset = 1'b1; in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_add();
        in_instr = 9'b000_01_10_00; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0; #1;
        checks++;
        if ({out_valid, out_op, out_reg1, out_reg2, do_swap} !== {1'b1, 3'd0, 2'd1, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL add act=%h exp=%h", {out_valid, out_op, out_reg1, out_reg2, do_swap},
                     {1'b1, 3'd0, 2'd1, 2'd2, 1'b0});
        end
        cycle();
    endtask

    task automatic test_swap_hold();
        in_instr = 9'b111_00_11_00; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({out_valid, out_op, out_reg1, out_reg2, in_ready, do_swap} !== {1'b1, 3'd7, 2'd0, 2'd3, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL swap_hold act=%h exp=%h", {out_valid, out_op, out_reg1, out_reg2, in_ready, do_swap},
                         {1'b1, 3'd7, 2'd0, 2'd3, 1'b0, 1'b0});
            end
            cycle();
        end
        out_ready = 1'b1; #1;
        checks++;
        if (do_swap !== 1'b1) begin
            errors++;
            $display("FAIL swap_strobe act=%b exp=1", do_swap);
        end
        cycle();
        checks++;
        if ({out_valid, do_swap} !== 2'b00) begin
            errors++;
            $display("FAIL swap_after act=%b exp=00", {out_valid, do_swap});
        end
    endtask

    task automatic test_ldi_gap();
        in_instr = 9'b110_10_00_00; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL ldi_gap act=%b exp=0", out_valid);
            end
        end
        in_instr = 9'h1A5; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0; #1;
        checks++;
        if ({out_valid, out_is_ldi, out_op, out_reg1, out_imm} !== {1'b1, 1'b1, 3'd6, 2'd2, 9'h1A5}) begin
            errors++;
            $display("FAIL ldi act=%h exp=%h", {out_valid, out_is_ldi, out_op, out_reg1, out_imm},
                     {1'b1, 1'b1, 3'd6, 2'd2, 9'h1A5});
        end
        cycle();
    endtask

    task automatic test_flush();
        in_instr = 9'b110_10_10_10; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        flush = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready act=%b exp=0", in_ready);
        end
        cycle();
        flush = 1'b0; in_instr = 9'b000_11_01_00;
        cycle();
        in_valid = 1'b0; #1;
        checks++;
        if ({out_valid, out_is_ldi, out_op, out_reg1, out_reg2} !== {1'b1, 1'b0, 3'd0, 2'd3, 2'd1}) begin
            errors++;
            $display("FAIL flush_ldi act=%h exp=%h", {out_valid, out_is_ldi, out_op, out_reg1, out_reg2},
                     {1'b1, 1'b0, 3'd0, 2'd3, 2'd1});
        end
        cycle();
    endtask

    task automatic test_reset_mid_ldi();
        in_instr = 9'b110_01_01_01; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0; reset = 1'b0;
        cycle();
        reset = 1'b1; in_valid = 1'b1; in_instr = 9'b000_01_01_00;
        cycle();
        in_valid = 1'b0; #1;
        checks++;
        if ({out_valid, out_is_ldi, out_op, out_reg1, out_imm} !== {1'b1, 1'b0, 3'd0, 2'd1, 9'd0}) begin
            errors++;
            $display("FAIL reset_mid_ldi act=%h exp=%h", {out_valid, out_is_ldi, out_op, out_reg1, out_imm},
                     {1'b1, 1'b0, 3'd0, 2'd1, 9'd0});
        end
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            in_instr  = 9'($urandom);
            if ($urandom_range(0, 2) == 0) in_instr[8:6] = 3'b110;
            cycle();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 20 && (pend || exp_q.size() != 0 || out_valid); k++) begin
            in_valid = pend;
            in_instr = 9'h0AB;
            cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0 || pend || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_drain act=%0d/%b/%b exp=0/0/0", exp_q.size(), pend, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int swaps  = 0;
        int stalls = 0;
`ifdef DECODE_STATS_EN
        n = 70000;
`else
        n = 300;
`endif
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_instr = {3'b111, 6'($urandom)};
            #1;
            if (do_swap) swaps++;
            if (in_ready !== 1'b1) stalls++;
            cycle();
        end
        in_valid = 1'b0; #1;
        if (do_swap) swaps++;
        cycle();
        checks++;
        if (swaps != n || stalls != 0) begin
            errors++;
            $display("FAIL back_to_back swaps=%0d stalls=%0d exp swaps=%0d stalls=0", swaps, stalls, n);
        end
`ifdef DECODE_STATS_EN
        checks++;
        if (stat_swaps !== 16'hFFFF || stat_ops !== 16'hFFFF) begin
            errors++;
            $display("FAIL stats act=%h/%h exp=ffff/ffff", stat_ops, stat_swaps);
        end
`endif
    endtask

    initial begin
        pend = 1'b0; pend_word = '0;
        test_reset();
        test_add();
        test_swap_hold();
        test_ldi_gap();
        test_flush();
        test_reset_mid_ldi();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
